// File: rtl/teras_bridge_pkg.sv
// Shared definitions for the teras Wishbone bridge: register map, STATUS/CTRL
// bit positions and the core-stall watchdog limit.
package teras_bridge_pkg;

    typedef enum logic [1:0] {
        REG_DATA_IN  = 2'd0,
        REG_DATA_OUT = 2'd1,
        REG_STATUS   = 2'd2,
        REG_CTRL     = 2'd3
    } reg_idx_e;

    localparam int ST_EMPTY     = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_IN_BUSY   = 10;
    localparam int ST_OVERFLOW  = 11;
    localparam int ST_UNDERFLOW = 12;

    localparam int CTRL_MIRROR_EN  = 0;
    localparam int CTRL_CLR_STICKY = 1;
    localparam int CTRL_FLUSH      = 2;

    localparam int WATCHDOG_LIMIT = 1024;
    // One extra bit so the counter can actually hold the limit value.
    localparam int WD_W = $clog2(WATCHDOG_LIMIT + 1);

    function automatic logic [31:0] pack_status(
        input logic [7:0] level,
        input logic       empty,
        input logic       full,
        input logic       in_busy,
        input logic       overflow,
        input logic       underflow
    );
        logic [31:0] s;
        s               = '0;
        s[7:0]          = level;
        s[ST_EMPTY]     = empty;
        s[ST_FULL]      = full;
        s[ST_IN_BUSY]   = in_busy;
        s[ST_OVERFLOW]  = overflow;
        s[ST_UNDERFLOW] = underflow;
        return s;
    endfunction

endpackage

// File: rtl/teras_bridge_wb_if.sv
// Wishbone-classic slave bus bundle between the management SoC and the bridge.
interface teras_bridge_wb_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/teras_sync_fifo.sv
// Single-clock FIFO with flush and a combinational head; DEPTH must be a power
// of two so the pointers wrap for free.
module teras_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

endmodule

// File: rtl/teras_bridge_wb.sv
// Wishbone-classic slave bridge to one teras systolic core stream port:
// register file, input holding buffer, result FIFO, sticky errors, pad mirror.
module teras_bridge_wb
    import teras_bridge_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          IO_PADS    = 38,
    parameter int          IO_LSB     = 8,
    parameter int          IO_W       = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    teras_bridge_wb_if.slave    wb,
    output logic                core_rts_o,
    input  logic                core_rtr_i,
    output logic [DATA_W-1:0]   core_data_o,
    input  logic                core_rts_i,
    output logic                core_rtr_o,
    input  logic [DATA_W-1:0]   core_data_i,
    output logic [IO_PADS-1:0]  io_out,
    output logic [IO_PADS-1:0]  io_oeb
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_in_valid;
    logic [DATA_W-1:0] r_in_data;
    logic              r_mirror_en;
    logic              r_ovf;
    logic              r_udf;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [IO_W-1:0]   r_mirror_data;
    logic              r_strobe;

    logic              w_hit;
    reg_idx_e          w_idx;
    logic              w_sel_all;
    logic              w_drain;
    logic              w_din_wr;
    logic              w_din_wait;
    logic              w_din_load;
    logic              w_ack_next;
    logic              w_dout_rd;
    logic              w_pop;
    logic              w_udf_set;
    logic              w_ctrl_wr;
    logic              w_clr;
    logic              w_flush;
    logic              w_push;
    logic              w_accept;
    logic              w_stall;
    logic              w_ovf_set;
    logic [31:0]       w_rd_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;
    logic [LVL_W-1:0]  w_fifo_level;
    logic              w_unused_adr;

    assign w_unused_adr = &{1'b0, wb.wbs_adr_i[1:0]};

    // Blocking on r_ack keeps a still-asserted strobe from starting a second access.
    assign w_hit     = wb.wbs_cyc_i & wb.wbs_stb_i & ~r_ack
                     & (wb.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign w_idx     = reg_idx_e'(wb.wbs_adr_i[3:2]);
    assign w_sel_all = (wb.wbs_sel_i == 4'hF);

    assign w_drain    = r_in_valid & core_rtr_i;
    assign w_din_wr   = w_hit & wb.wbs_we_i & (w_idx == REG_DATA_IN);
    assign w_din_wait = w_din_wr & w_sel_all & r_in_valid & ~core_rtr_i;
    assign w_din_load = w_din_wr & w_sel_all & ~w_din_wait;
    assign w_ack_next = w_hit & ~w_din_wait;

    assign w_dout_rd = w_hit & ~wb.wbs_we_i & (w_idx == REG_DATA_OUT);
    assign w_pop     = w_dout_rd & ~w_fifo_empty;
    assign w_udf_set = w_dout_rd & w_fifo_empty;

    assign w_ctrl_wr = w_hit & wb.wbs_we_i & (w_idx == REG_CTRL) & w_sel_all;
    assign w_clr     = w_ctrl_wr & wb.wbs_dat_i[CTRL_CLR_STICKY];
    assign w_flush   = w_ctrl_wr & wb.wbs_dat_i[CTRL_FLUSH];

    assign w_push    = core_rts_i & ~w_fifo_full;
    assign w_accept  = w_push & ~w_flush;
    assign w_stall   = core_rts_i & w_fifo_full;
    assign w_ovf_set = w_stall & (r_wd_cnt == WD_W'(WATCHDOG_LIMIT));

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign core_rts_o   = r_in_valid;
    assign core_data_o  = r_in_data;
    assign core_rtr_o   = ~w_fifo_full;

    always_comb begin
        w_rd_data = '0;
        case (w_idx)
            REG_DATA_IN: w_rd_data = '0;
            REG_DATA_OUT: begin
                if (!w_fifo_empty) begin
                    w_rd_data = 32'(w_fifo_head);
                end
            end
            REG_STATUS: w_rd_data = pack_status(8'(w_fifo_level), w_fifo_empty, w_fifo_full,
                                                r_in_valid, r_ovf, r_udf);
            REG_CTRL: w_rd_data[CTRL_MIRROR_EN] = r_mirror_en;
        endcase
    end

    teras_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (core_data_i),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // Bus side: ack, read data (zero outside an ack), input buffer, control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_in_valid  <= 1'b0;
            r_in_data   <= '0;
            r_mirror_en <= 1'b0;
        end else begin
            r_ack <= w_ack_next;
            r_dat <= (w_hit && !wb.wbs_we_i) ? w_rd_data : '0;
            if (w_din_load) begin
                r_in_valid <= 1'b1;
                r_in_data  <= wb.wbs_dat_i[DATA_W-1:0];
            end else if (w_drain) begin
                r_in_valid <= 1'b0;
            end
            if (w_ctrl_wr) begin
                r_mirror_en <= wb.wbs_dat_i[CTRL_MIRROR_EN];
            end
        end
    end

    // Sticky flags: a set in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_wd_cnt <= '0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~w_clr);
            r_udf <= w_udf_set | (r_udf & ~w_clr);
            if (!w_stall) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != WD_W'(WATCHDOG_LIMIT)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mirror_data <= '0;
            r_strobe      <= 1'b0;
        end else begin
            r_strobe <= w_accept & r_mirror_en;
            if (w_accept && r_mirror_en) begin
                r_mirror_data <= core_data_i[IO_W-1:0];
            end
        end
    end

    // Pad map: IO_W data lanes from IO_LSB, strobe just above, everything else idle.
    for (genvar gi = 0; gi < IO_PADS; gi++) begin : g_pad
        if (gi >= IO_LSB && gi < IO_LSB + IO_W) begin : g_lane
            assign io_out[gi] = r_mirror_data[gi-IO_LSB];
            assign io_oeb[gi] = ~r_mirror_en;
        end else if (gi == IO_LSB + IO_W) begin : g_strobe
            assign io_out[gi] = r_strobe;
            assign io_oeb[gi] = ~r_mirror_en;
        end else begin : g_idle
            assign io_out[gi] = 1'b0;
            assign io_oeb[gi] = 1'b1;
        end
    end

endmodule

// File: tb/tb_teras_bridge_wb.sv
// Scoreboard bench for teras_bridge_wb: stimulus queues expected responses,
// monitors on the bus, core stream and pad mirror pop and compare them.
module tb_teras_bridge_wb;
    import teras_bridge_pkg::*;

    localparam int          DATA_W     = 32;
    localparam int          FIFO_DEPTH = 8;
    localparam int          IO_PADS    = 38;
    localparam int          IO_LSB     = 8;
    localparam int          IO_W       = 24;
    localparam logic [31:0] BASE       = 32'h3000_0000;
    localparam logic [37:0] LANE_MASK  = 38'h01_FFFF_FF00;
    localparam logic [37:0] OEB_MIRROR = ~LANE_MASK;
    localparam logic [37:0] ALL_ONES   = {IO_PADS{1'b1}};

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_rts_o, core_rtr_i, core_rts_i, core_rtr_o;
    logic [DATA_W-1:0] core_data_o, core_data_i;
    logic [IO_PADS-1:0] io_out, io_oeb;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t wb_q[$];
    exp_t core_q[$];
    exp_t mir_q[$];
    exp_t wb_e, core_e, mir_e;
    logic prev_ack = 1'b0;
    logic [37:0] idle_bits;

    always #5 clk = ~clk;

    teras_bridge_wb_if wb ();

    teras_bridge_wb #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_BASE  (BASE),
        .IO_PADS    (IO_PADS),
        .IO_LSB     (IO_LSB),
        .IO_W       (IO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wb),
        .core_rts_o  (core_rts_o),
        .core_rtr_i  (core_rtr_i),
        .core_data_o (core_data_o),
        .core_rts_i  (core_rts_i),
        .core_rtr_o  (core_rtr_o),
        .core_data_i (core_data_i),
        .io_out      (io_out),
        .io_oeb      (io_oeb)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic expect_wb(input string name, input logic [31:0] exp);
        wb_q.push_back('{name: name, exp: exp});
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat);
        @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_adr_i = BASE | {28'h0, idx, 2'b00};
        wb.wbs_dat_i = dat;
        wb.wbs_sel_i = sel;
        lat = 0;
        @(negedge clk);
        while (!wb.wbs_ack_o && lat < 2000) begin
            lat++;
            @(negedge clk);
        end
        if (!wb.wbs_ack_o) begin
            n_total++;
            $display("FAIL wb timeout: reg %0d got no ack, required ack within 2000 cycles", idx);
        end
        @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_sel_i = '0;
    endtask

    task automatic wr(input string name, input logic [1:0] idx, input logic [31:0] dat);
        int lat;
        expect_wb({name, " ack"}, 32'h0);
        wb_xfer(1'b1, idx, dat, 4'hF, lat);
        chk({name, " latency"}, 64'(lat), 64'd1);
    endtask

    task automatic rd(input string name, input logic [1:0] idx, input logic [31:0] exp);
        int lat;
        expect_wb(name, exp);
        wb_xfer(1'b0, idx, 32'h0, 4'hF, lat);
        chk({name, " latency"}, 64'(lat), 64'd1);
    endtask

    task automatic core_push(input logic [31:0] d);
        @(posedge clk);
        #1;
        core_rts_i  = 1'b1;
        core_data_i = d;
        @(posedge clk);
        #1;
        core_rts_i  = 1'b0;
    endtask

    // Bus monitor: every ack consumes one expected read-data entry.
    always @(negedge clk) begin
        if (rst_n && wb.wbs_ack_o) begin
            chk("ack single cycle", 64'(prev_ack), 64'd0);
            if (wb_q.size() == 0) begin
                n_total++;
                $display("FAIL wb unexpected ack: dat 0x%08h, required no ack", wb.wbs_dat_o);
            end else begin
                wb_e = wb_q.pop_front();
                $display("wb   %s dat=0x%08h", wb_e.name, wb.wbs_dat_o);
                chk(wb_e.name, 64'(wb.wbs_dat_o), 64'(wb_e.exp));
            end
        end
        prev_ack <= wb.wbs_ack_o;
    end

    always @(negedge clk) begin
        if (rst_n && core_rts_o && core_rtr_i) begin
            if (core_q.size() == 0) begin
                n_total++;
                $display("FAIL core unexpected word: 0x%08h, required none", core_data_o);
            end else begin
                core_e = core_q.pop_front();
                $display("core %s data=0x%08h", core_e.name, core_data_o);
                chk(core_e.name, 64'(core_data_o), 64'(core_e.exp));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && io_out[IO_LSB+IO_W]) begin
            if (mir_q.size() == 0) begin
                n_total++;
                $display("FAIL mirror unexpected strobe: lane 0x%06h, required none", io_out[IO_LSB +: IO_W]);
            end else begin
                mir_e = mir_q.pop_front();
                $display("pad  %s lane=0x%06h", mir_e.name, io_out[IO_LSB +: IO_W]);
                chk(mir_e.name, 64'(io_out[IO_LSB +: IO_W]), 64'(mir_e.exp));
                chk("mirror strobe oeb", 64'(io_oeb), 64'(OEB_MIRROR));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not reach its end");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_sel_i = '0;
        core_rtr_i   = 1'b0;
        core_rts_i   = 1'b0;
        core_data_i  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ack", 64'(wb.wbs_ack_o), 64'd0);
        chk("reset dat", 64'(wb.wbs_dat_o), 64'd0);
        chk("reset core_rts_o", 64'(core_rts_o), 64'd0);
        chk("reset core_rtr_o", 64'(core_rtr_o), 64'd1);
        chk("reset io_out", 64'(io_out), 64'd0);
        chk("reset io_oeb", 64'(io_oeb), 64'(ALL_ONES));
        @(posedge clk);
        #1 rst_n = 1'b1;

        rd("STATUS after reset", REG_STATUS, 32'h0000_0100);
        chk("idle core_rtr_o", 64'(core_rtr_i | core_rtr_o), 64'd1);
        chk("idle io_oeb", 64'(io_oeb), 64'(ALL_ONES));

        // Input path: free buffer, then a stall released by the core.
        core_rtr_i = 1'b1;
        core_q.push_back('{name: "DATA_IN deadbeef", exp: 32'hDEADBEEF});
        wr("DATA_IN deadbeef", REG_DATA_IN, 32'hDEADBEEF);
        chk("core_rts_o one cycle", 64'(core_rts_o), 64'd0);

        core_rtr_i = 1'b0;
        core_q.push_back('{name: "DATA_IN 11111111", exp: 32'h1111_1111});
        wr("DATA_IN 11111111", REG_DATA_IN, 32'h1111_1111);
        rd("STATUS in_busy", REG_STATUS, 32'h0000_0500);

        core_q.push_back('{name: "DATA_IN 22222222", exp: 32'h2222_2222});
        fork
            begin : stalled_write
                int lat;
                expect_wb("DATA_IN stalled ack", 32'h0);
                wb_xfer(1'b1, REG_DATA_IN, 32'h2222_2222, 4'hF, lat);
                chk("DATA_IN stall latency", 64'(lat), 64'd5);
            end
            begin : release_core
                repeat (5) @(posedge clk);
                #1 core_rtr_i = 1'b1;
            end
        join

        begin : partial_sel
            int lat;
            expect_wb("DATA_IN partial sel ack", 32'h0);
            wb_xfer(1'b1, REG_DATA_IN, 32'h0000_0055, 4'h3, lat);
            chk("DATA_IN partial sel latency", 64'(lat), 64'd1);
        end
        rd("DATA_IN readback", REG_DATA_IN, 32'h0);

        // Result FIFO: fill, check full, drain in order.
        for (int i = 1; i <= 8; i++) core_push(32'(i));
        chk("core_rtr_o when full", 64'(core_rtr_o), 64'd0);
        rd("STATUS full", REG_STATUS, 32'h0000_0208);
        for (int i = 1; i <= 8; i++) begin
            rd($sformatf("DATA_OUT #%0d", i), REG_DATA_OUT, 32'(i));
            if (i == 3) rd("STATUS level 5", REG_STATUS, 32'h0000_0005);
        end
        rd("STATUS drained", REG_STATUS, 32'h0000_0100);
        chk("core_rtr_o after drain", 64'(core_rtr_o), 64'd1);

        rd("DATA_OUT empty", REG_DATA_OUT, 32'h0);
        rd("STATUS underflow", REG_STATUS, 32'h0000_1100);
        wr("CTRL clear sticky", REG_CTRL, 32'h2);
        rd("STATUS after clear", REG_STATUS, 32'h0000_0100);
        rd("CTRL readback 0", REG_CTRL, 32'h0);

        // Pad mirror.
        wr("CTRL mirror on", REG_CTRL, 32'h1);
        rd("CTRL readback 1", REG_CTRL, 32'h1);
        chk("mirror io_oeb", 64'(io_oeb), 64'(OEB_MIRROR));
        mir_q.push_back('{name: "mirror abcdef", exp: 32'h00AB_CDEF});
        core_push(32'h00AB_CDEF);
        @(posedge clk);
        #1;
        chk("mirror strobe low", 64'(io_out[IO_LSB+IO_W]), 64'd0);
        chk("mirror data held", 64'(io_out[IO_LSB +: IO_W]), 64'h00AB_CDEF);
        idle_bits = io_out & OEB_MIRROR;
        chk("mirror idle pads", 64'(idle_bits), 64'd0);
        rd("DATA_OUT mirrored", REG_DATA_OUT, 32'h00AB_CDEF);
        wr("CTRL mirror off", REG_CTRL, 32'h0);
        chk("mirror off io_oeb", 64'(io_oeb), 64'(ALL_ONES));

        // Stall watchdog, set-beats-clear, flush.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            core_rts_i  = 1'b1;
            core_data_i = 32'hA0 + 32'(i);
        end
        @(posedge clk);
        #1 core_data_i = 32'h99;
        repeat (1000) @(posedge clk);
        rd("STATUS before watchdog", REG_STATUS, 32'h0000_0208);
        repeat (100) @(posedge clk);
        rd("STATUS overflow", REG_STATUS, 32'h0000_0A08);
        wr("CTRL clear while stalled", REG_CTRL, 32'h2);
        rd("STATUS overflow kept", REG_STATUS, 32'h0000_0A08);
        core_rts_i = 1'b0;
        wr("CTRL clear idle", REG_CTRL, 32'h2);
        rd("STATUS overflow cleared", REG_STATUS, 32'h0000_0208);
        wr("CTRL flush", REG_CTRL, 32'h4);
        rd("STATUS after flush", REG_STATUS, 32'h0000_0100);
        chk("core_rtr_o after flush", 64'(core_rtr_o), 64'd1);

        // Reset during a stalled DATA_IN write.
        wr("CTRL mirror on again", REG_CTRL, 32'h1);
        core_rtr_i = 1'b0;
        wr("DATA_IN 33333333", REG_DATA_IN, 32'h3333_3333);
        @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = 1'b1;
        wb.wbs_adr_i = BASE;
        wb.wbs_dat_i = 32'h4444_4444;
        wb.wbs_sel_i = 4'hF;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset ack", 64'(wb.wbs_ack_o), 64'd0);
        chk("async reset dat", 64'(wb.wbs_dat_o), 64'd0);
        chk("async reset core_rts_o", 64'(core_rts_o), 64'd0);
        chk("async reset core_rtr_o", 64'(core_rtr_o), 64'd1);
        chk("async reset io_out", 64'(io_out), 64'd0);
        chk("async reset io_oeb", 64'(io_oeb), 64'(ALL_ONES));
        @(posedge clk);
        #1;
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
        wb.wbs_sel_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        core_rtr_i = 1'b1;
        rd("STATUS after mid reset", REG_STATUS, 32'h0000_0100);
        rd("CTRL after mid reset", REG_CTRL, 32'h0);

        repeat (3) @(posedge clk);
        chk("wb queue drained", 64'(wb_q.size()), 64'd0);
        chk("core queue drained", 64'(core_q.size()), 64'd0);
        chk("mirror queue drained", 64'(mir_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
